// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
// Data width, FSM state encoding and baud divider derivation.
`timescale 1ns/1ps
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud_rate
  );
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous FIFO with wrap-bit pointers; no push/pop bypass.
// Ports: push_i/pop_i/data_i in; data_o (head), full_o, empty_o, count_o out.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             push_ok;
  logic             pop_ok;

  // full/empty come from registered pointers only, so a pop
  // never frees a slot for a push in the same cycle
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign count_o = wr_q - rd_q;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO front end feeding a shift FSM.
// Ports: tx_data/tx_valid/tx_ready push side; tx_serial, tx_busy, tx_done, fifo_count.
`timescale 1ns/1ps
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [UART_DATA_BITS-1:0]     tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int BW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BITW = $clog2(UART_DATA_BITS);

  uart_state_e               state_q;
  logic [BW-1:0]             baud_q;
  logic [BITW-1:0]           bit_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      serial_q;
  logic                      busy_q;
  logic                      done_q;

  logic                      full;
  logic                      empty;
  logic [UART_DATA_BITS-1:0] head;
  logic                      wrap;
  logic                      pop;

  assign wrap = (baud_q == BW'(CPB - 1));
  assign pop  = !empty &&
                ((state_q == IDLE) ||
                 (state_q == STOP && wrap));

  assign tx_ready  = !full;
  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_valid),
    .pop_i   (pop),
    .data_i  (tx_data),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          serial_q <= 1'b1;
          if (!empty) begin
            shift_q  <= head;
            baud_q   <= '0;
            bit_q    <= '0;
            serial_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= START;
          end
        end
        START: begin
          if (wrap) begin
            baud_q   <= '0;
            serial_q <= shift_q[0];
            state_q  <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (wrap) begin
            baud_q <= '0;
            if (bit_q == BITW'(UART_DATA_BITS - 1)) begin
              serial_q <= 1'b1;
              state_q  <= STOP;
            end else begin
              // line is registered: present the next bit now
              shift_q  <= shift_q >> 1;
              serial_q <= shift_q[1];
              bit_q    <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          // registered pulse lands on the final stop cycle
          if (baud_q == BW'(CPB - 2)) done_q <= 1'b1;
          if (wrap) begin
            baud_q <= '0;
            if (!empty) begin
              shift_q  <= head;
              bit_q    <= '0;
              serial_q <= 1'b0;
              state_q  <= START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench: frame-time reference model plus line decoder.
// Drives tx_data/tx_valid/rst, checks every output each cycle.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

  localparam int CPB   = 16;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;
  logic [4:0] fifo_count;

  uart_tx_buffered #(
    .CLK_FREQ   (160),
    .BAUD_RATE  (10),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_serial  (tx_serial),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: queue of waiting bytes, byte in flight,
  // and position t inside the current 10-bit frame
  logic [7:0] q[$];
  logic [7:0] sent[$];
  logic [7:0] cur;
  bit         act;
  int         t;
  bit         accepted;

  bit         dec_act;
  int         dcnt;
  logic [7:0] dbyte;
  int         ndec;
  int         ndone;
  int         max_cnt;

  function automatic logic exp_line();
    if (!act) return 1'b1;
    if (t < CPB) return 1'b0;
    if (t < 9 * CPB) return cur[(t - CPB) / CPB];
    return 1'b1;
  endfunction

  task automatic model_clear();
    q.delete();
    sent.delete();
    act     = 0;
    t       = 0;
    dec_act = 0;
    dcnt    = 0;
  endtask

  task automatic model_edge();
    bit can_pop;
    accepted = 0;
    if (rst) begin
      model_clear();
    end else begin
      can_pop  = (q.size() > 0);
      accepted = tx_valid && (q.size() < DEPTH);
      if (act) begin
        if (t == FRAME - 1) begin
          if (can_pop) begin
            cur = q.pop_front();
            sent.push_back(cur);
            t = 0;
          end else begin
            act = 0;
          end
        end else begin
          t++;
        end
      end else if (can_pop) begin
        cur = q.pop_front();
        sent.push_back(cur);
        act = 1;
        t   = 0;
      end
      if (accepted) q.push_back(tx_data);
    end
  endtask

  task automatic decode();
    int h;
    h = CPB / 2;
    if (!dec_act) begin
      if (tx_serial == 1'b0) begin
        dec_act = 1;
        dcnt    = 0;
      end
    end else begin
      dcnt++;
      if (dcnt == h) begin
        check("dec_start", tx_serial, 0);
      end else if (dcnt == h + 9 * CPB) begin
        check("dec_stop", tx_serial, 1);
        dec_act = 0;
        ndec++;
        if (sent.size() == 0) check("dec_extra", 1, 0);
        else check("dec_byte", dbyte, sent.pop_front());
      end else if (dcnt > h && (dcnt - h) % CPB == 0) begin
        dbyte[(dcnt - h) / CPB - 1] = tx_serial;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("serial", tx_serial, exp_line());
    check("busy", tx_busy, act);
    check("done", tx_done, act && t == FRAME - 1);
    check("count", fifo_count, q.size());
    check("ready", tx_ready, q.size() < DEPTH);
    if (tx_done) ndone++;
    if (int'(fifo_count) > max_cnt) max_cnt = fifo_count;
    if (!rst) decode();
  endtask

  task automatic push(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((act || q.size() > 0 || dec_act) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", n < budget, 1);
    check("undecoded", sent.size(), 0);
  endtask

  initial begin
    model_clear();
    ndec = 0; ndone = 0; max_cnt = 0;

    // reset state
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_count", fifo_count, 0);
    check("rst_serial", tx_serial, 1);

    // single byte
    ndone = 0; ndec = 0;
    push(8'h41);
    check("sb_count", fifo_count, 1);
    step();
    check("sb_start", tx_serial, 0);
    check("sb_pop", fifo_count, 0);
    drain(400);
    check("sb_done", ndone, 1);
    check("sb_dec", ndec, 1);

    // back-to-back
    ndone = 0; ndec = 0;
    push(8'h41);
    push(8'h42);
    push(8'h43);
    drain(700);
    check("b2b_done", ndone, 3);
    check("b2b_dec", ndec, 3);

    // full FIFO
    ndec = 0; max_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tx_valid = 1'b1;
      tx_data  = 8'(8'h10 + i);
      step();
    end
    tx_valid = 1'b0;
    check("full_max", max_cnt, DEPTH);
    drain(4000);
    check("full_dec", ndec, DEPTH + 1);

    // concurrent push and pop
    begin
      int n;
      push(8'hA0);
      push(8'hA1);
      n = 0;
      while (!(act && t == FRAME - 1) && n < 400) begin
        step();
        n++;
      end
      check("cc_timeout", n < 400, 1);
      check("cc_pre", fifo_count, 1);
      push(8'hA2);
      check("cc_count", fifo_count, 1);
      drain(700);
    end

    // reset mid-frame
    begin
      int n;
      for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
      check("mr_queued", fifo_count, 5);
      n = 0;
      while (!(act && t == CPB + 3 * CPB + 5) && n < 400) begin
        step();
        n++;
      end
      check("mr_timeout", n < 400, 1);
      check("mr_low", tx_serial, 1'b0 ^ cur[3]);
      #2;
      rst = 1'b1;
      model_clear();
      #1;
      check("mr_serial", tx_serial, 1);
      check("mr_count", fifo_count, 0);
      check("mr_busy", tx_busy, 0);
      check("mr_done", tx_done, 0);
      step();
      rst = 1'b0;
      ndec = 0;
      push(8'h55);
      drain(400);
      check("mr_dec", ndec, 1);
    end

    // random gaps, pointer wrap
    ndec = 0;
    for (int i = 0; i < 40; i++) begin
      int gap;
      int n;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
      tx_valid = 1'b1;
      tx_data  = 8'($urandom);
      n = 0;
      accepted = 0;
      while (!accepted && n < 400) begin
        step();
        n++;
      end
      check("rnd_accept", accepted, 1);
      tx_valid = 1'b0;
    end
    drain(8000);
    check("rnd_dec", ndec, 40);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
